stream_demux_1_2: RTL and testbench

Registered 1-to-2 stream demultiplexer. It is the receive-side counterpart of the 2:1 multiplexer: one valid/ready input stream is routed to output port `a` or port `b` by a `select` bit. The bit is sampled on the first beat of each packet and held until the last beat. Each output has a 2-entry buffer, so back-pressure on one output never corrupts the other and the block sustains one beat per cycle.

---
 rtl/stream_demux_pkg.sv | 15 +
 rtl/stream_buf2.sv | 57 +++++
 rtl/stream_demux_1_2.sv | 117 +++++++++++
 tb/tb_stream_demux_1_2.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE_A,
        ROUTE_B
    } route_state_t;

    localparam int unsigned BUF_DEPTH = 2;

    // Occupancy of a per-port buffer, 0..BUF_DEPTH.
    typedef logic [$clog2(BUF_DEPTH + 1)-1:0] occ_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry FIFO; entry 0 is always the head, so the head needs no read mux.
module stream_buf2
    import stream_demux_pkg::*;
#(
    parameter type beat_t = logic
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  beat_t push_beat,
    input  logic  pop,
    output beat_t head,
    output logic  full,
    output logic  empty
);

    occ_t  count_q, count_d;
    beat_t e0_q, e0_d;
    beat_t e1_q, e1_d;
    logic  do_push, do_pop;
    occ_t  occ_after_pop;

    always_comb begin
        do_push       = push && !full;
        do_pop        = pop && !empty;
        e0_d          = e0_q;
        e1_d          = e1_q;
        occ_after_pop = count_q - occ_t'(do_pop);
        if (do_pop) begin
            e0_d = e1_q;
        end
        // The new beat lands in whichever slot is free once the pop has shifted.
        if (do_push) begin
            if (occ_after_pop == '0) begin
                e0_d = push_beat;
            end else begin
                e1_d = push_beat;
            end
        end
        count_d = occ_after_pop + occ_t'(do_push);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign head  = e0_q;
    assign full  = (count_q == occ_t'(BUF_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/stream_demux_1_2.sv
// Registered 1-to-2 stream demux: select is latched per packet, each port has a 2-beat buffer.
module stream_demux_1_2
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              select,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    output logic              a_last,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    output logic              b_last,
    input  logic              b_ready,
    output logic [CNT_W-1:0]  a_pkt_cnt,
    output logic [CNT_W-1:0]  b_pkt_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    route_state_t state_q, state_d;
    logic         dest_b, accept, push_a, push_b;
    logic         a_full, a_empty, b_full, b_empty;
    beat_t        in_beat, a_head, b_head;
    logic [CNT_W-1:0] a_cnt_q, b_cnt_q;

    assign in_beat = '{data: in_data, last: in_last};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                IDLE:            if (!in_last) state_d = select ? ROUTE_B : ROUTE_A;
                ROUTE_A, ROUTE_B: if (in_last) state_d = IDLE;
                default:         state_d = IDLE;
            endcase
        end
    end

    // in_ready only looks at registered occupancy, never at a_ready/b_ready.
    always_comb begin
        unique case (state_q)
            IDLE:    dest_b = select;
            ROUTE_B: dest_b = 1'b1;
            default: dest_b = 1'b0;
        endcase
        in_ready = rst_n && (dest_b ? !b_full : !a_full);
        accept   = in_valid && in_ready;
        push_a   = accept && !dest_b;
        push_b   = accept && dest_b;
    end

    stream_buf2 #(
        .beat_t (beat_t)
    ) u_buf_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_beat (in_beat),
        .pop       (a_ready),
        .head      (a_head),
        .full      (a_full),
        .empty     (a_empty)
    );

    stream_buf2 #(
        .beat_t (beat_t)
    ) u_buf_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_beat (in_beat),
        .pop       (b_ready),
        .head      (b_head),
        .full      (b_full),
        .empty     (b_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (push_a && in_last) a_cnt_q <= a_cnt_q + CNT_W'(1);
            if (push_b && in_last) b_cnt_q <= b_cnt_q + CNT_W'(1);
        end
    end

    assign a_valid   = !a_empty;
    assign a_data    = a_head.data;
    assign a_last    = a_head.last;
    assign b_valid   = !b_empty;
    assign b_data    = b_head.data;
    assign b_last    = b_head.last;
    assign a_pkt_cnt = a_cnt_q;
    assign b_pkt_cnt = b_cnt_q;

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Directed bench for stream_demux_1_2 (CNT_W=4 so the counter wrap is reachable).
module tb_stream_demux_1_2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_last, select, in_ready;
    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, a_ready;
    logic       b_valid, b_last, b_ready;
    logic [3:0] a_pkt_cnt, b_pkt_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_demux_1_2 #(
        .DATA_W (8),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .select    (select),
        .in_ready  (in_ready),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .a_pkt_cnt (a_pkt_cnt),
        .b_pkt_cnt (b_pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        select   = s;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset then idle
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_cnt", a_pkt_cnt, 0);
        chk("rst_b_cnt", b_pkt_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // Packet steering: select toggles mid-packet but must be ignored
        a_ready = 1'b1;
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        chk("steer_ready", in_ready, 1);
        step();
        chk("steer_a1_valid", a_valid, 1);
        chk("steer_a1_data", a_data, 8'h11);
        chk("steer_a1_last", a_last, 0);
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        step();
        chk("steer_a2_data", a_data, 8'h22);
        chk("steer_a2_last", a_last, 0);
        chk("steer_b2_valid", b_valid, 0);
        drive(1'b1, 8'h33, 1'b1, 1'b1);
        step();
        chk("steer_a3_data", a_data, 8'h33);
        chk("steer_a3_last", a_last, 1);
        chk("steer_b3_valid", b_valid, 0);
        chk("steer_a_cnt", a_pkt_cnt, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("steer_a_drained", a_valid, 0);
        chk("steer_b_cnt", b_pkt_cnt, 0);

        // Back-pressure on b with a 4-beat packet
        drive(1'b1, 8'h01, 1'b0, 1'b1);
        chk("bp_ready0", in_ready, 1);
        step();
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        chk("bp_ready1", in_ready, 1);
        step();
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        chk("bp_ready_full", in_ready, 0);
        step();
        chk("bp_ready_stall", in_ready, 0);
        chk("bp_b_head", b_data, 8'h01);
        b_ready = 1'b1;
        #1;
        chk("bp_ready_no_comb", in_ready, 0);
        step();
        chk("bp_ready_rise", in_ready, 1);
        chk("bp_b_02", b_data, 8'h02);
        step();
        chk("bp_b_03", b_data, 8'h03);
        drive(1'b1, 8'h04, 1'b1, 1'b0);
        step();
        chk("bp_b_04", b_data, 8'h04);
        chk("bp_b_04_last", b_last, 1);
        chk("bp_b_cnt", b_pkt_cnt, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("bp_b_drained", b_valid, 0);

        // Independent ports: a stalled with 2 beats, b still takes a packet
        a_ready = 1'b0;
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hA2, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("ind_a_full_ready", in_ready, 0);
        drive(1'b1, 8'h5A, 1'b1, 1'b1);
        chk("ind_b_ready", in_ready, 1);
        step();
        chk("ind_b_valid", b_valid, 1);
        chk("ind_b_data", b_data, 8'h5A);
        chk("ind_b_last", b_last, 1);
        chk("ind_a_head", a_data, 8'hA1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("ind_b_drained", b_valid, 0);
        chk("ind_a_still", a_data, 8'hA1);
        chk("ind_a_cnt", a_pkt_cnt, 2);
        chk("ind_b_cnt", b_pkt_cnt, 2);

        // Mid-packet reset
        a_ready = 1'b1;
        step(); step();
        chk("mid_a_empty", a_valid, 0);
        a_ready = 1'b0;
        drive(1'b1, 8'hC1, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hC2, 1'b0, 1'b1);
        step();
        chk("mid_a_valid", a_valid, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_a_cleared", a_valid, 0);
        chk("mid_a_cnt", a_pkt_cnt, 0);
        chk("mid_b_cnt", b_pkt_cnt, 0);
        drive(1'b1, 8'h77, 1'b1, 1'b1);
        step();
        chk("mid_b_valid", b_valid, 1);
        chk("mid_b_data", b_data, 8'h77);
        chk("mid_a_idle", a_valid, 0);
        chk("mid_b_cnt_new", b_pkt_cnt, 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();

        // Counter wrap on a 4-bit counter
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            step();
        end
        chk("wrap_a_cnt16", a_pkt_cnt, 0);
        drive(1'b1, 8'h10, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_a_cnt17", a_pkt_cnt, 1);
        chk("wrap_b_cnt", b_pkt_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
